// File: rtl/pcie_egress_pkg.sv
// Shared TLP header codes and helpers for the egress path.
package pcie_egress_pkg;

    localparam logic [1:0] FMT_3DW_DATA  = 2'b10;
    localparam logic [1:0] FMT_4DW_DATA  = 2'b11;
    localparam logic [4:0] TYPE_MWR      = 5'b00000;
    localparam logic [4:0] TYPE_CPL      = 5'b01010;
    localparam logic [2:0] CPL_STATUS_SC = 3'b000;

    localparam int HDR_LEN_W  = 10;
    localparam int HDR_BC_W   = 12;
    localparam int PAYLOAD_CW = 11;

    typedef enum logic {
        TLP_MWR  = 1'b0,
        TLP_CPLD = 1'b1
    } tlp_kind_e;

    function automatic logic [31:0] hdr_dw0(input logic [1:0] fmt, input logic [4:0] typ,
                                            input logic [HDR_LEN_W-1:0] len);
        return {1'b0, fmt, typ, 14'h0, len};
    endfunction

    // Length field of zero means the maximum of 1024 DWs.
    function automatic logic [PAYLOAD_CW-1:0] payload_dw(input logic [HDR_LEN_W-1:0] cnt);
        return (cnt == '0) ? 11'd1024 : {1'b0, cnt};
    endfunction

endpackage

// File: rtl/pcie_egress_if.sv
// 32-bit AXI-Stream link between the egress block and the PCIe core TX port.
interface pcie_egress_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/pcie_egress_skid.sv
// Two-entry synchronous FIFO with occupancy output, buffering payload reads.
module pcie_egress_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic [1:0]   count_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == 1'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == 2'd0);

endmodule

// File: rtl/pcie_egress.sv
// Device-to-host TLP transmitter: builds MWr/CplD headers and streams payload from the local buffer.
// Define PCIE_EGRESS_64BIT_ADDR_EN to emit 4DW MWr headers when the upper address is non-zero.
module pcie_egress
    import pcie_egress_pkg::*;
#(
    parameter int BUF_ADDR_W     = 10,
    parameter int MAX_PAYLOAD_DW = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_send_mwr_stb,
    input  logic                  i_send_cpl_stb,
    input  logic [9:0]            i_dword_count,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_addr_hi,
    input  logic [15:0]           i_requester_id,
    input  logic [15:0]           i_completer_id,
    input  logic [7:0]            i_tag,
    input  logic [6:0]            i_cpl_lower_addr,
    input  logic [BUF_ADDR_W-1:0] i_buf_base,
    output logic                  o_buf_re,
    output logic [BUF_ADDR_W-1:0] o_buf_addr,
    input  logic [31:0]           i_buf_dat,
    pcie_egress_if.master         axis,
    output logic                  o_busy,
    output logic                  o_done_stb,
    output logic                  o_err_stb
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [BUF_ADDR_W-1:0] ADDR_ONE = 1;

    logic [1:0]            state_q, state_d;
    logic [31:0]           hdr_q [4];
    logic [31:0]           new_hdr [4];
    logic [1:0]            hdr_idx_q;
    logic [1:0]            hdr_last_q;
    logic [10:0]           rd_left_q;
    logic [10:0]           tx_left_q;
    logic [BUF_ADDR_W-1:0] rd_addr_q;
    logic                  re_q;
    logic                  err_q, err_d;

    tlp_kind_e             cmd_kind;
    logic [10:0]           cmd_len;
    logic                  cmd_any;
    logic                  too_long;
    logic                  accept;
    logic                  use_4dw;
    logic [31:0]           addr_dw;
    logic [3:0]            lbe;
    logic                  beat;
    logic                  hdr_done;
    logic                  pop;
    logic                  data_done;
    logic                  buf_re;
    logic [2:0]            occupancy;
    logic [31:0]           fifo_dat;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;

`ifdef PCIE_EGRESS_64BIT_ADDR_EN
    assign use_4dw = (i_addr_hi != 32'h0);
    logic unused_bits;
    assign unused_bits = ^i_addr[1:0];
`else
    assign use_4dw = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{i_addr_hi, i_addr[1:0]};
`endif

    // A simultaneous CplD and MWr strobe keeps the CplD; the MWr is reported as dropped.
    assign cmd_kind = i_send_cpl_stb ? TLP_CPLD : TLP_MWR;
    assign cmd_len  = payload_dw(i_dword_count);
    assign cmd_any  = i_enable && (i_send_mwr_stb || i_send_cpl_stb);
    assign too_long = cmd_len > 11'(MAX_PAYLOAD_DW);
    assign accept   = (state_q == S_IDLE) && cmd_any && !too_long;
    assign err_d    = cmd_any && ((state_q != S_IDLE) || too_long ||
                                  (i_send_mwr_stb && i_send_cpl_stb));
    assign addr_dw  = {i_addr[31:2], 2'b00};
    assign lbe      = (cmd_len > 11'd1) ? 4'hF : 4'h0;

    always_comb begin
        new_hdr[0] = hdr_dw0(FMT_3DW_DATA, TYPE_MWR, i_dword_count);
        new_hdr[1] = {i_requester_id, i_tag, lbe, 4'hF};
        new_hdr[2] = addr_dw;
        new_hdr[3] = 32'h0;
        if (cmd_kind == TLP_CPLD) begin
            new_hdr[0] = hdr_dw0(FMT_3DW_DATA, TYPE_CPL, i_dword_count);
            new_hdr[1] = {i_completer_id, CPL_STATUS_SC, 1'b0, {i_dword_count, 2'b00}};
            new_hdr[2] = {i_requester_id, i_tag, 1'b0, i_cpl_lower_addr};
        end else if (use_4dw) begin
            new_hdr[0] = hdr_dw0(FMT_4DW_DATA, TYPE_MWR, i_dword_count);
            new_hdr[2] = i_addr_hi;
            new_hdr[3] = addr_dw;
        end
    end

    assign beat      = axis.valid && axis.ready;
    assign hdr_done  = (state_q == S_HDR) && beat && (hdr_idx_q == hdr_last_q);
    assign pop       = (state_q == S_DATA) && beat;
    assign data_done = pop && (tx_left_q == 11'd1);

    // Reads start during the header so the first payload word is usually waiting.
    assign occupancy = {1'b0, fifo_count} + {2'b00, re_q};
    assign buf_re    = ((state_q == S_HDR) || (state_q == S_DATA)) &&
                       (rd_left_q != 11'd0) && (occupancy < 3'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_HDR;
            S_HDR:   if (hdr_done)  state_d = S_DATA;
            S_DATA:  if (data_done) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hdr
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hdr_q[gi] <= '0;
                end else if (accept) begin
                    hdr_q[gi] <= new_hdr[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hdr_idx_q  <= 2'd0;
            hdr_last_q <= 2'd2;
            rd_left_q  <= 11'd0;
            tx_left_q  <= 11'd0;
            rd_addr_q  <= '0;
            re_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q    <= buf_re;
            err_q   <= err_d;
            if (accept) begin
                hdr_idx_q  <= 2'd0;
                hdr_last_q <= ((cmd_kind == TLP_MWR) && use_4dw) ? 2'd3 : 2'd2;
                rd_left_q  <= cmd_len;
                tx_left_q  <= cmd_len;
                rd_addr_q  <= i_buf_base;
            end else begin
                if ((state_q == S_HDR) && beat) hdr_idx_q <= hdr_idx_q + 2'd1;
                if (buf_re) begin
                    rd_left_q <= rd_left_q - 11'd1;
                    rd_addr_q <= rd_addr_q + ADDR_ONE;
                end
                if (pop) tx_left_q <= tx_left_q - 11'd1;
            end
        end
    end

    pcie_egress_skid #(.W(32)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (re_q),
        .push_data_i (i_buf_dat),
        .pop_i       (pop),
        .pop_data_o  (fifo_dat),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        axis.valid = (state_q == S_HDR) || ((state_q == S_DATA) && !fifo_empty);
        axis.data  = 32'h0;
        axis.last  = 1'b0;
        if (state_q == S_HDR) begin
            axis.data = hdr_q[hdr_idx_q];
        end else if ((state_q == S_DATA) && !fifo_empty) begin
            axis.data = fifo_dat;
            axis.last = (tx_left_q == 11'd1);
        end
        axis.keep = axis.valid ? 4'hF : 4'h0;
    end

    assign o_buf_re   = buf_re;
    assign o_buf_addr = rd_addr_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done_stb = (state_q == S_DONE);
    assign o_err_stb  = err_q;

endmodule

// File: tb/tb_pcie_egress.sv
// Self-checking bench for pcie_egress: directed and randomized TLPs against a beat-list reference model.
module tb_pcie_egress;

    localparam int MAXP = 128;
`ifdef PCIE_EGRESS_64BIT_ADDR_EN
    localparam bit ADDR64 = 1'b1;
`else
    localparam bit ADDR64 = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en, mwr_stb, cpl_stb;
    logic [9:0]  dword;
    logic [31:0] addr, addr_hi;
    logic [15:0] req, cpl_id;
    logic [7:0]  tag;
    logic [6:0]  lower;
    logic [9:0]  base;
    logic        buf_re;
    logic [9:0]  buf_addr;
    logic [31:0] buf_dat;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [1024];
    logic [9:0]  rd_addrs [$];
    logic        rd_pend = 1'b0;
    logic [9:0]  rd_pend_addr = '0;

    pcie_egress_if axis_if ();

    pcie_egress #(.BUF_ADDR_W(10), .MAX_PAYLOAD_DW(MAXP)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_enable         (en),
        .i_send_mwr_stb   (mwr_stb),
        .i_send_cpl_stb   (cpl_stb),
        .i_dword_count    (dword),
        .i_addr           (addr),
        .i_addr_hi        (addr_hi),
        .i_requester_id   (req),
        .i_completer_id   (cpl_id),
        .i_tag            (tag),
        .i_cpl_lower_addr (lower),
        .i_buf_base       (base),
        .o_buf_re         (buf_re),
        .o_buf_addr       (buf_addr),
        .i_buf_dat        (buf_dat),
        .axis             (axis_if.master),
        .o_busy           (busy),
        .o_done_stb       (done),
        .o_err_stb        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: registered read, data one cycle after the read enable.
    always @(negedge clk) begin
        rd_pend      = buf_re;
        rd_pend_addr = buf_addr;
        if (buf_re) rd_addrs.push_back(buf_addr);
    end
    always @(posedge clk) begin
        if (rd_pend) buf_dat <= mem[rd_pend_addr];
    end

    task automatic chk(input string tag_s, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag_s, obs, expv);
        end
    endtask

    function automatic logic next_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return cyc[0];
            2:       return 1'($urandom_range(0, 1));
            default: return ($urandom_range(0, 3) == 0);
        endcase
    endfunction

    task automatic run_tlp(input bit is_cpl, input bit both, input logic [9:0] len10,
                           input logic [31:0] a, input logic [31:0] ahi, input logic [15:0] rq,
                           input logic [15:0] cp, input logic [7:0] tg, input logic [6:0] lw,
                           input logic [9:0] bs, input int mode, input int inject_at);
        logic [32:0] expq [$];
        logic [32:0] e;
        int n, cyc, rd_start;
        bit four, pend, chk_now, prev_stall;
        logic [31:0] prev_d;
        logic prev_l;
        n = (len10 == 10'd0) ? 1024 : int'(len10);
        if (is_cpl) begin
            expq.push_back({1'b0, 32'h4A00_0000 | 32'(len10)});
            expq.push_back({1'b0, cp, 3'b000, 1'b0, 12'((n * 4) % 4096)});
            expq.push_back({1'b0, rq, tg, 1'b0, lw});
        end else begin
            four = ADDR64 && (ahi != 32'h0);
            expq.push_back({1'b0, (four ? 32'h6000_0000 : 32'h4000_0000) | 32'(len10)});
            expq.push_back({1'b0, rq, tg, (n > 1) ? 4'hF : 4'h0, 4'hF});
            if (four) expq.push_back({1'b0, ahi});
            expq.push_back({1'b0, a & 32'hFFFF_FFFC});
        end
        for (int i = 0; i < n; i++) expq.push_back({(i == n - 1), mem[(int'(bs) + i) % 1024]});

        rd_start = rd_addrs.size();
        @(posedge clk); #1;
        en = 1'b1; dword = len10; addr = a; addr_hi = ahi; req = rq; cpl_id = cp;
        tag = tg; lower = lw; base = bs;
        mwr_stb = !is_cpl || both; cpl_stb = is_cpl;
        axis_if.ready = next_ready(mode, 0);
        @(posedge clk); #1;
        mwr_stb = 1'b0; cpl_stb = 1'b0;
        axis_if.ready = next_ready(mode, 1);
        cyc = 1; pend = 0; chk_now = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;
        @(negedge clk);
        chk("accept_busy", 64'(busy), 64'(1));
        chk("accept_err", 64'(err), 64'(both));
        chk("dw0_valid", 64'(axis_if.valid), 64'(1));
        while (1) begin
            if (chk_now) begin
                chk("busy_strobe_err", 64'(err), 64'(1));
                chk_now = 0;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(axis_if.valid), 64'(1));
                chk("stall_data", 64'(axis_if.data), 64'(prev_d));
                chk("stall_last", 64'(axis_if.last), 64'(prev_l));
            end
            if (axis_if.valid && axis_if.ready) begin
                e = expq.pop_front();
                chk("beat_data", 64'(axis_if.data), 64'(e[31:0]));
                chk("beat_last", 64'(axis_if.last), 64'(e[32]));
                chk("beat_keep", 64'(axis_if.keep), 64'(4'hF));
            end
            prev_stall = axis_if.valid && !axis_if.ready;
            prev_d = axis_if.data;
            prev_l = axis_if.last;
            if (expq.size() == 0) break;
            if (cyc >= 5000) begin
                chk("timeout", 64'(expq.size()), 64'(0));
                break;
            end
            @(posedge clk); #1;
            cyc++;
            axis_if.ready = next_ready(mode, cyc);
            if (pend) begin pend = 0; chk_now = 1; end
            if (cyc == inject_at) begin mwr_stb = 1'b1; pend = 1; end
            else mwr_stb = 1'b0;
            @(negedge clk);
        end
        mwr_stb = 1'b0;
        @(posedge clk); #1;
        axis_if.ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(1));
        @(negedge clk);
        chk("done_clear", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_valid", 64'(axis_if.valid), 64'(0));
        chk("read_count", 64'(rd_addrs.size() - rd_start), 64'(n));
        for (int i = 0; i < n && (rd_start + i) < rd_addrs.size(); i++)
            chk("read_addr", 64'(rd_addrs[rd_start + i]), 64'((int'(bs) + i) % 1024));
    endtask

    task automatic expect_reject(input logic [9:0] len10, input bit enable);
        @(posedge clk); #1;
        en = enable; dword = len10; mwr_stb = 1'b1;
        @(posedge clk); #1;
        mwr_stb = 1'b0;
        @(negedge clk);
        chk("rej_err", 64'(err), 64'(enable));
        chk("rej_valid", 64'(axis_if.valid), 64'(0));
        chk("rej_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("rej_err_pulse", 64'(err), 64'(0));
        chk("rej_no_read", 64'(buf_re), 64'(0));
        chk("rej_valid2", 64'(axis_if.valid), 64'(0));
        en = 1'b1;
    endtask

    initial begin
        int acc;
        bit hit;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b0; en = 1'b0; mwr_stb = 1'b0; cpl_stb = 1'b0; dword = '0;
        addr = '0; addr_hi = '0; req = '0; cpl_id = '0; tag = '0; lower = '0; base = '0;
        axis_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(axis_if.valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_re", 64'(buf_re), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_last", 64'(axis_if.last), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        run_tlp(0, 0, 10'd1, 32'h1000_0010, 32'h0, 16'h0100, 16'h0, 8'h05, 7'h0, 10'd17, 0, -1);
        run_tlp(0, 0, 10'd4, 32'h2000_0104, 32'h0, 16'h0123, 16'h0, 8'h11, 7'h0, 10'd40, 1, 2);
        run_tlp(1, 0, 10'd2, 32'h0, 32'h0, 16'h0100, 16'h0200, 8'h07, 7'h10, 10'd100, 0, -1);
        run_tlp(1, 1, 10'd3, 32'h0, 32'h0, 16'h0abc, 16'h0def, 8'h33, 7'h22, 10'd1022, 2, -1);
        expect_reject(10'd129, 1'b1);
        expect_reject(10'd0, 1'b1);
        expect_reject(10'd4, 1'b0);
        run_tlp(0, 0, 10'd128, 32'h3000_0000, 32'h0, 16'h0001, 16'h0, 8'h01, 7'h0, 10'd960, 2, -1);
        run_tlp(0, 0, 10'd1, 32'h0000_0020, 32'h0000_0001, 16'h0100, 16'h0, 8'h09, 7'h0, 10'd5, 0, -1);

        // Reset while the second payload beat is on the bus.
        @(posedge clk); #1;
        en = 1'b1; dword = 10'd4; addr = 32'h4000_0000; addr_hi = '0; base = 10'd200;
        mwr_stb = 1'b1; axis_if.ready = 1'b1;
        @(posedge clk); #1;
        mwr_stb = 1'b0;
        acc = 0; hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (axis_if.valid && acc == 4) hit = 1;
            else if (axis_if.valid && axis_if.ready) acc++;
        end
        chk("mid_reset_reached", 64'(hit), 64'(1));
        #1 rst = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(axis_if.valid), 64'(0));
        chk("mid_reset_busy", 64'(busy), 64'(0));
        chk("mid_reset_re", 64'(buf_re), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        run_tlp(0, 0, 10'd1, 32'h5000_0008, 32'h0, 16'h0042, 16'h0, 8'h0a, 7'h0, 10'd300, 0, -1);

        for (int t = 0; t < 12; t++) begin
            logic [9:0] l;
            l = ($urandom_range(0, 5) == 0) ? 10'(MAXP) : 10'($urandom_range(1, 12));
            run_tlp(1'($urandom_range(0, 1)), 1'b0, l, $urandom,
                    ($urandom_range(0, 1) == 1) ? $urandom : 32'h0,
                    16'($urandom), 16'($urandom), 8'($urandom), 7'($urandom),
                    10'($urandom_range(0, 1023)), $urandom_range(0, 3), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
